// File: rtl/alu_acc_sequencer_if.sv
// Command/result bus of alu_acc_sequencer; ResZero exists only with ALU_ACC_ZFLAG_EN.
// Both channels use valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface alu_acc_sequencer_if #(
   parameter int WIDTH = 4
);
   logic             Clear;
   logic             CmdValid;
   logic             CmdReady;
   logic [3:0]       CmdOp;
   logic [WIDTH-1:0] CmdData;
   logic             CmdUseCarry;
   logic             ResValid;
   logic             ResReady;
   logic [WIDTH-1:0] ResData;
   logic             ResCarry;
`ifdef ALU_ACC_ZFLAG_EN
   logic             ResZero;

   modport master (
      output Clear, CmdValid, CmdOp, CmdData, CmdUseCarry, ResReady,
      input  CmdReady, ResValid, ResData, ResCarry, ResZero
   );

   modport slave (
      input  Clear, CmdValid, CmdOp, CmdData, CmdUseCarry, ResReady,
      output CmdReady, ResValid, ResData, ResCarry, ResZero
   );
`else
   modport master (
      output Clear, CmdValid, CmdOp, CmdData, CmdUseCarry, ResReady,
      input  CmdReady, ResValid, ResData, ResCarry
   );

   modport slave (
      input  Clear, CmdValid, CmdOp, CmdData, CmdUseCarry, ResReady,
      output CmdReady, ResValid, ResData, ResCarry
   );
`endif
endinterface

// File: rtl/alu_acc_sequencer.sv
// Accumulator/command sequencer wrapped around an external WIDTH-bit ALU (IDLE -> EXEC -> RESP).
// Define ALU_ACC_ZFLAG_EN to add the registered ResZero flag on the result channel.
module alu_acc_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic                Clock,
   input  logic                Resetn,
   alu_acc_sequencer_if.slave  bus,
   output logic [WIDTH-1:0]    AluA,
   output logic [WIDTH-1:0]    AluB,
   output logic                AluCin,
   output logic [2:0]          AluControl,
   input  logic [WIDTH-1:0]    AluOutput,
   input  logic                AluCout,
   output logic                Busy,
   output logic [1:0]          DbgState
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] acc, acc_nx;
   logic [WIDTH-1:0] breg, breg_nx;
   logic [3:0]       opreg, opreg_nx;
   logic             carry, carry_nx;
   logic             cinreg, cinreg_nx;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state  <= S_IDLE;
         acc    <= '0;
         breg   <= '0;
         opreg  <= '0;
         carry  <= 1'b0;
         cinreg <= 1'b0;
      end else begin
         state  <= state_nx;
         acc    <= acc_nx;
         breg   <= breg_nx;
         opreg  <= opreg_nx;
         carry  <= carry_nx;
         cinreg <= cinreg_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      acc_nx    = acc;
      breg_nx   = breg;
      opreg_nx  = opreg;
      carry_nx  = carry;
      cinreg_nx = cinreg;
      case (state)
         S_IDLE: begin
            // Clear wins over a pending command; the command simply waits.
            if (bus.Clear) begin
               acc_nx   = '0;
               carry_nx = 1'b0;
            end else if (bus.CmdValid) begin
               opreg_nx  = bus.CmdOp;
               breg_nx   = bus.CmdData;
               cinreg_nx = bus.CmdUseCarry & carry;
               state_nx  = S_EXEC;
            end
         end
         S_EXEC: begin
            if (opreg[3]) begin
               acc_nx = breg;
            end else begin
               acc_nx   = AluOutput;
               carry_nx = AluCout;
            end
            state_nx = S_RESP;
         end
         S_RESP: begin
            if (bus.ResReady) begin
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

`ifdef ALU_ACC_ZFLAG_EN
   logic zreg;

   // Tracks acc register-for-register so it is valid in the same cycle as ResData.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         zreg <= 1'b0;
      end else begin
         zreg <= (acc_nx == '0);
      end
   end

   assign bus.ResZero = zreg;
`endif

   // Gating with Resetn keeps CmdReady low while reset is asserted.
   assign bus.CmdReady = Resetn & (state == S_IDLE) & ~bus.Clear;
   assign bus.ResValid = (state == S_RESP);
   assign bus.ResData  = acc;
   assign bus.ResCarry = carry;

   assign AluA       = acc;
   assign AluB       = breg;
   assign AluCin     = cinreg;
   assign AluControl = opreg[2:0];

   assign Busy     = (state != S_IDLE);
   assign DbgState = state;

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Directed + random bench for alu_acc_sequencer with a behavioural 4-bit ALU attached.
// Scoreboard: expected {carry,data} pushed when a command is driven, popped when ResValid rises.
module tb_alu_acc_sequencer;
   localparam int WIDTH = 4;

   logic             Clock;
   logic             Resetn;
   logic [WIDTH-1:0] AluA, AluB, AluOutput;
   logic             AluCin, AluCout;
   logic [2:0]       AluControl;
   logic             Busy;
   logic [1:0]       DbgState;

   alu_acc_sequencer_if #(.WIDTH(WIDTH)) bus ();

   alu_acc_sequencer #(.WIDTH(WIDTH)) dut (
      .Clock      (Clock),
      .Resetn     (Resetn),
      .bus        (bus.slave),
      .AluA       (AluA),
      .AluB       (AluB),
      .AluCin     (AluCin),
      .AluControl (AluControl),
      .AluOutput  (AluOutput),
      .AluCout    (AluCout),
      .Busy       (Busy),
      .DbgState   (DbgState)
   );

   // ---------------- clock / reset ----------------
   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // ---------------- ALU behavioural model ----------------
   function automatic logic [WIDTH:0] alu_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic cin, input logic [2:0] ctl);
      logic [WIDTH:0] r;
      case (ctl)
         3'b000:  r = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
         3'b001:  r = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
         3'b110:  r = {1'b0, a[WIDTH-2:0], a[WIDTH-1]};
         3'b111:  r = {1'b0, a[0], a[WIDTH-1:1]};
         default: r = {1'b0, a & b};
      endcase
      return r;
   endfunction

   always_comb {AluCout, AluOutput} = alu_ref(AluA, AluB, AluCin, AluControl);

   // ---------------- scoreboard ----------------
   logic [WIDTH:0] exp_q[$];
   int passed = 0;
   int total  = 0;
   int fails  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver ----------------
   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_LROT = 4'b0110;
   localparam logic [3:0] OP_RROT = 4'b0111;
   localparam logic [3:0] OP_LOAD = 4'b1000;

   task automatic do_cmd(input string tag, input logic [3:0] op, input logic [WIDTH-1:0] data,
                         input logic uc, input logic [WIDTH-1:0] ed, input logic ec, input int hold);
      int n;
      logic [WIDTH:0] exp_v;
      exp_q.push_back({ec, ed});
      @(negedge Clock);
      bus.CmdOp       = op;
      bus.CmdData     = data;
      bus.CmdUseCarry = uc;
      bus.CmdValid    = 1'b1;
      n = 0;
      while (bus.CmdReady !== 1'b1 && n < 20) begin
         @(negedge Clock);
         n++;
      end
      check({tag, "_accept"}, (n < 20), 1'b1);
      @(posedge Clock);
      @(negedge Clock);
      bus.CmdValid = 1'b0;
      check({tag, "_exec_valid"}, bus.ResValid, 1'b0);
      check({tag, "_exec_state"}, DbgState, 2'd1);
      @(negedge Clock);
      check({tag, "_resp_valid"}, bus.ResValid, 1'b1);
      check({tag, "_resp_busy"}, Busy, 1'b1);
      if (exp_q.size() == 0) begin
         check({tag, "_queue"}, 0, 1);
      end else begin
         exp_v = exp_q.pop_front();
         check({tag, "_result"}, {bus.ResCarry, bus.ResData}, exp_v);
`ifdef ALU_ACC_ZFLAG_EN
         check({tag, "_zero"}, bus.ResZero, (exp_v[WIDTH-1:0] == '0));
`endif
      end
      // Stall the result channel while offering a conflicting command that must be ignored.
      for (int i = 0; i < hold; i++) begin
         bus.CmdOp    = OP_LOAD;
         bus.CmdData  = ~ed;
         bus.CmdValid = 1'b1;
         check({tag, "_hold_cmdready"}, bus.CmdReady, 1'b0);
         @(negedge Clock);
         check({tag, "_hold_valid"}, bus.ResValid, 1'b1);
         check({tag, "_hold_data"}, {bus.ResCarry, bus.ResData}, {ec, ed});
      end
      bus.CmdValid = 1'b0;
      bus.ResReady = 1'b1;
      @(posedge Clock);
      @(negedge Clock);
      bus.ResReady = 1'b0;
      check({tag, "_done_valid"}, bus.ResValid, 1'b0);
      check({tag, "_done_ready"}, bus.CmdReady, 1'b1);
      check({tag, "_done_acc"}, AluA, ed);
   endtask

   // ---------------- stimulus ----------------
   logic [WIDTH-1:0] ref_acc, rd;
   logic             ref_carry, ruc;
   logic [3:0]       rop;
   logic [WIDTH:0]   rr;

   initial begin
      Resetn          = 1'b0;
      bus.Clear       = 1'b0;
      bus.CmdValid    = 1'b0;
      bus.CmdOp       = '0;
      bus.CmdData     = '0;
      bus.CmdUseCarry = 1'b0;
      bus.ResReady    = 1'b0;
      repeat (2) @(negedge Clock);
      check("reset_outputs", {bus.CmdReady, bus.ResValid, bus.ResData, bus.ResCarry, Busy,
                              AluA, AluB, AluCin, AluControl, DbgState}, 0);
      Resetn = 1'b1;
      @(negedge Clock);
      check("post_reset_ready", bus.CmdReady, 1'b1);

      // 1: load then add, with a 4-cycle stall on the ADD result
      do_cmd("t1_load", OP_LOAD, 4'h5, 1'b0, 4'h5, 1'b0, 0);
      do_cmd("t1_add",  OP_ADD,  4'h3, 1'b0, 4'h8, 1'b0, 4);
      // 2: wrap-around and carry-in chaining
      do_cmd("t2_load", OP_LOAD, 4'hF, 1'b0, 4'hF, 1'b0, 0);
      do_cmd("t2_add",  OP_ADD,  4'h1, 1'b0, 4'h0, 1'b1, 0);
      do_cmd("t2_addc", OP_ADD,  4'h2, 1'b1, 4'h3, 1'b0, 1);
      // 3: subtract with borrow, rotates
      do_cmd("t3_load", OP_LOAD, 4'h3, 1'b0, 4'h3, 1'b0, 0);
      do_cmd("t3_sub",  OP_SUB,  4'h5, 1'b0, 4'hE, 1'b1, 0);
      do_cmd("t3_ld9",  OP_LOAD, 4'h9, 1'b0, 4'h9, 1'b1, 0);
      do_cmd("t3_rrot", OP_RROT, 4'h0, 1'b0, 4'hC, 1'b0, 0);
      do_cmd("t3_lrot", OP_LROT, 4'h0, 1'b0, 4'h9, 1'b0, 2);

      // 5: Clear in IDLE beats a pending command and zeroes acc and carry
      do_cmd("t5_ldf",  OP_LOAD, 4'hF, 1'b0, 4'hF, 1'b0, 0);
      do_cmd("t5_add",  OP_ADD,  4'h1, 1'b0, 4'h0, 1'b1, 0);
      do_cmd("t5_ld7",  OP_LOAD, 4'h7, 1'b0, 4'h7, 1'b1, 0);
      bus.Clear    = 1'b1;
      bus.CmdValid = 1'b1;
      bus.CmdOp    = OP_LOAD;
      bus.CmdData  = 4'hA;
      #1;
      check("t5_clear_cmdready", bus.CmdReady, 1'b0);
      @(negedge Clock);
      check("t5_clear_acc", AluA, 4'h0);
      check("t5_clear_carry", bus.ResCarry, 1'b0);
      check("t5_clear_state", DbgState, 2'd0);
      bus.Clear    = 1'b0;
      bus.CmdValid = 1'b0;
      do_cmd("t5_addc", OP_ADD, 4'h2, 1'b1, 4'h2, 1'b0, 0);

      // 6: asynchronous reset while a command is in EXEC
      @(negedge Clock);
      bus.CmdOp    = OP_LOAD;
      bus.CmdData  = 4'h6;
      bus.CmdValid = 1'b1;
      @(posedge Clock);
      @(negedge Clock);
      bus.CmdValid = 1'b0;
      check("t6_in_exec", DbgState, 2'd1);
      Resetn = 1'b0;
      #1;
      check("t6_reset_outputs", {bus.CmdReady, bus.ResValid, bus.ResData, bus.ResCarry, Busy,
                                 AluA, AluB, AluCin, AluControl, DbgState}, 0);
      @(negedge Clock);
      Resetn = 1'b1;
      @(negedge Clock);
      check("t6_ready", bus.CmdReady, 1'b1);
      check("t6_acc", AluA, 4'h0);
      @(negedge Clock);
      check("t6_no_result", bus.ResValid, 1'b0);

      // Random commands against the reference accumulator (acc=0, carry=0 after reset)
      ref_acc   = '0;
      ref_carry = 1'b0;
      for (int i = 0; i < 12; i++) begin
         case ($urandom_range(0, 4))
            0:       rop = OP_ADD;
            1:       rop = OP_SUB;
            2:       rop = OP_LOAD;
            3:       rop = OP_LROT;
            default: rop = OP_RROT;
         endcase
         rd  = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
         ruc = 1'($urandom_range(0, 1));
         if (rop[3]) begin
            ref_acc = rd;
         end else begin
            rr        = alu_ref(ref_acc, rd, ruc & ref_carry, rop[2:0]);
            ref_acc   = rr[WIDTH-1:0];
            ref_carry = rr[WIDTH];
         end
         do_cmd("rand", rop, rd, ruc, ref_acc, ref_carry, $urandom_range(0, 2));
      end

      check("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   // Global watchdog so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
